regfile_sb: RTL
===============

# regfile_sb

Parametrised, scoreboarded register file for the pipelined RISC-V core: NUM_RD combinational read ports, one synchronous write port, x0 hard-wired to zero, optional write-to-read bypass. A per-register busy scoreboard lets decode stall on pending writebacks. A reset-triggered clear sweep zeroes the array one entry per cycle before the file reports ready. It replaces the single-cycle core's two-read register file and sits between decode (reads, issue) and writeback (write).

## Interface
- DATA_WIDTH, 32, register width
- ADR_WIDTH, 5, register index width; depth = 2**ADR_WIDTH
- NUM_RD, 2, number of read ports (1..4)
- DBG_REG, 10, index exposed on dbg (a0)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- we  in  1  write enable (writeback)
- wa  in  ADR_WIDTH  write index
- wd  in  DATA_WIDTH  write data
- ra  in  NUM_RD x ADR_WIDTH  read indices
- rd  out  NUM_RD x DATA_WIDTH  read data
- rd_busy  out  NUM_RD  selected register has a pending write
- issue_en  in  1  decode issued an instruction writing issue_rd
- issue_rd  in  ADR_WIDTH  destination of issued instruction
- ready  out  1  clear sweep finished; file usable
- dbg  out  DATA_WIDTH  registered contents of DBG_REG

## Operation
- FSM states CLEAR, RUN. rst at an edge -> CLEAR, sweep counter = 1, busy vector = 0.
- CLEAR: each edge writes 0 to entry counter, counter increments; edge that clears entry 2**ADR_WIDTH-1 moves to RUN. rst held keeps counter at 1.
- CLEAR: we and issue_en ignored; rd = 0, rd_busy = 0, ready = 0. dbg shows stored value (0 once swept).
- RUN: ready = 1; we && wa != 0 writes wd to entry wa at edge.
- Writes to x0 dropped always; ra = 0 reads 0 with rd_busy = 0.
- Scoreboard (RUN only): issue_en && issue_rd != 0 sets busy[issue_rd]; we && wa != 0 clears busy[wa]. Same index both in one cycle: set wins (new producer). Different indices: both take effect.
- rd_busy[i] = busy[ra[i]], masked per Configuration.
- Read ports independent; any ports may address the same index.
- rst mid-operation: sweep restarts from entry 1, all busy bits cleared, in-flight write on that edge dropped.

## Timing
- Reset values: ready 0, rd 0, rd_busy 0; dbg 0 once DBG_REG swept (edge DBG_REG after rst release).
- ready rises 2**ADR_WIDTH-1 cycles after the last edge with rst high (31 for defaults).
- Read latency 0 (combinational from ra and array). Write visible in array the edge after we.
- Scoreboard set/clear visible on rd_busy the cycle after the edge.
- dbg reflects array state, never bypassed; updates the cycle after a write.

## Configuration
- REGFILE_BYPASS_EN defined: in RUN, if we && wa != 0 && wa == ra[i], rd[i] = wd and rd_busy[i] = 0 in the same cycle (write-through forwarding).
- Undefined: rd[i] returns old array value in the write cycle; rd_busy[i] stays 1 until the edge clears it. All else identical.

## Structure
- regfile_pkg: state enum (CLEAR, RUN), default parameter constants, x0 index constant.
- One sub-module: regfile_scoreboard (busy vector, set/clear priority, per-port lookup); array, sweep FSM and bypass muxing stay in regfile_sb.

## Test plan
- rst 1 cycle, release -> ready 0 for 31 cycles then 1; every ra reads 0; dbg 0.
- RUN: write x5 = 0xDEADBEEF, next cycle ra[0]=5 -> rd[0]=0xDEADBEEF; write x0 = 0x1234 -> ra=0 reads 0.
- issue_en rd=7 -> rd_busy=1 for ra=7 next cycle; we wa=7 -> rd_busy 0 after edge; issue 7 and write 7 same cycle -> stays busy.
- Bypass: we wa=3 wd=0x55, ra[1]=3 same cycle -> with REGFILE_BYPASS_EN rd[1]=0x55, rd_busy=0; without, old value and busy held.
- Write x10=0xA5A5A5A5 -> dbg=0xA5A5A5A5 next cycle; rst at sweep counter 12 -> counter restarts at 1, ready low 31 further cycles, busy bits cleared.
- NUM_RD=4: all four ports read distinct and identical indices concurrently -> correct data on each.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the scoreboarded register file.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } rf_state_t;

  localparam int unsigned RF_DATA_WIDTH = 32;
  localparam int unsigned RF_ADR_WIDTH  = 5;
  localparam int unsigned RF_NUM_RD     = 2;
  localparam int unsigned RF_DBG_REG    = 10;

  // Architectural zero register index.
  localparam int unsigned RF_X0 = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy vector: issue sets, writeback clears, set wins on the
// same index. Callers gate both strobes (RUN only, never x0).
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int unsigned ADR_WIDTH = RF_ADR_WIDTH,
  parameter int unsigned NUM_RD    = RF_NUM_RD
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_set_en,
  input  logic [ADR_WIDTH-1:0]        i_set_idx,
  input  logic                        i_clr_en,
  input  logic [ADR_WIDTH-1:0]        i_clr_idx,
  input  logic [NUM_RD*ADR_WIDTH-1:0] i_ra,
  output logic [NUM_RD-1:0]           o_busy
);

  localparam int unsigned DEPTH = 2**ADR_WIDTH;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;

  // Next busy vector: clear applied first so a same-index set overrides it.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en) w_busy_nxt[i_clr_idx] = 1'b0;
    if (i_set_en) w_busy_nxt[i_set_idx] = 1'b1;
  end

  // Busy register with synchronous clear on reset.
  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  // Per-port lookup of the current busy bit.
  always_comb begin
    o_busy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      o_busy[i] = r_busy[i_ra[i*ADR_WIDTH +: ADR_WIDTH]];
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Scoreboarded register file: NUM_RD combinational reads, one synchronous
// write, x0 reads zero, reset-triggered clear sweep before ready.
// Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_sb import regfile_pkg::*; #(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned ADR_WIDTH  = RF_ADR_WIDTH,
  parameter int unsigned NUM_RD     = RF_NUM_RD,
  parameter int unsigned DBG_REG    = RF_DBG_REG
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [ADR_WIDTH-1:0]         wa,
  input  logic [DATA_WIDTH-1:0]        wd,
  input  logic [NUM_RD*ADR_WIDTH-1:0]  ra,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         issue_en,
  input  logic [ADR_WIDTH-1:0]         issue_rd,
  output logic                         ready,
  output logic [DATA_WIDTH-1:0]        dbg
);

  localparam int unsigned          DEPTH   = 2**ADR_WIDTH;
  localparam logic [ADR_WIDTH-1:0] X0      = ADR_WIDTH'(RF_X0);
  localparam logic [ADR_WIDTH-1:0] LAST    = ADR_WIDTH'(DEPTH-1);
  localparam logic [ADR_WIDTH-1:0] DBG_IDX = ADR_WIDTH'(DBG_REG);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  rf_state_t             r_state;
  rf_state_t             w_state_nxt;
  logic [ADR_WIDTH-1:0]  r_sweep;
  logic                  w_run;
  logic                  w_wr;
  logic                  w_iss;
  logic [NUM_RD-1:0]     w_sb_busy;

  assign w_run = (r_state == ST_RUN);
  assign w_wr  = w_run && we && (wa != X0);
  assign w_iss = w_run && issue_en && (issue_rd != X0);
  assign ready = w_run;

  // State and sweep counter; reset restarts the sweep at entry 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_sweep <= ADR_WIDTH'(1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) r_sweep <= r_sweep + ADR_WIDTH'(1);
    end
  end

  // Leave CLEAR on the edge that zeroes the last entry.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_CLEAR && r_sweep == LAST) w_state_nxt = ST_RUN;
  end

  // Array: sweep zeroes one entry per cycle, then normal writeback.
  // Entry 0 is never written; every read path masks it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_CLEAR) r_mem[r_sweep] <= '0;
      else if (w_wr)           r_mem[wa]      <= wd;
    end
  end

  regfile_scoreboard #(
    .ADR_WIDTH (ADR_WIDTH),
    .NUM_RD    (NUM_RD)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .i_set_en  (w_iss),
    .i_set_idx (issue_rd),
    .i_clr_en  (w_wr),
    .i_clr_idx (wa),
    .i_ra      (ra),
    .o_busy    (w_sb_busy)
  );

  // Read ports: zero outside RUN and for x0, optional forwarding of the write.
  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (w_run && ra[i*ADR_WIDTH +: ADR_WIDTH] != X0) begin
        rd[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[ra[i*ADR_WIDTH +: ADR_WIDTH]];
        rd_busy[i]                     = w_sb_busy[i];
`ifdef REGFILE_BYPASS_EN
        if (w_wr && wa == ra[i*ADR_WIDTH +: ADR_WIDTH]) begin
          rd[i*DATA_WIDTH +: DATA_WIDTH] = wd;
          rd_busy[i]                     = 1'b0;
        end
`endif
      end
    end
  end

  assign dbg = (DBG_IDX == X0) ? '0 : r_mem[DBG_IDX];

endmodule
